// File: rtl/bus_master_arbiter_if.sv
// =============================================================================
// bus_master_arbiter_if : DMA request/grant and 68000 BR/BG/BGACK bus bundle
// Rev 1.0
// =============================================================================
`default_nettype none

interface bus_master_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] done;
   logic [NREQ-1:0] gnt;
   logic [1:0]      owner;
   logic            busy;
   logic            br_n;
   logic            bg_n;
   logic            bgack_n;
   logic            as_n;

   modport master (
      input  req, done, bg_n, as_n,
      output gnt, owner, busy, br_n, bgack_n
   );

   modport slave (
      output req, done, bg_n, as_n,
      input  gnt, owner, busy, br_n, bgack_n
   );
endinterface

`default_nettype wire

// File: rtl/bus_master_arbiter.sv
// =============================================================================
// bus_master_arbiter : round-robin DMA bus arbiter with 68000 BR/BG/BGACK
// Rev 1.0
// =============================================================================
`default_nettype none

module bus_master_arbiter #(
   parameter int NREQ     = 3,
   parameter int HOLD_MAX = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  phi2,
   bus_master_arbiter_if.master  bus
);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_WAIT_BG  = 3'd1;
   localparam logic [2:0] c_OWN      = 3'd2;
   localparam logic [2:0] c_DRAIN    = 3'd3;
   localparam logic [2:0] c_REL      = 3'd4;
   localparam logic [7:0] c_HOLD_MAX = 8'(HOLD_MAX);

   logic [2:0]      r_state;
   logic [1:0]      r_owner;
   logic [1:0]      r_rr;
   logic [7:0]      r_hold;
   logic            r_busy;
   logic            r_br_n;
   logic            r_bgack_n;

   logic [3:0]      w_req4;
   logic [3:0]      w_done4;
   logic            w_any_req;
   logic [1:0]      w_win;
   logic [7:0]      w_hold_nxt;
   logic            w_own_exit;
   logic [NREQ-1:0] w_gnt;

   always_comb begin
      w_req4             = '0;
      w_done4            = '0;
      w_req4[NREQ-1:0]   = bus.req;
      w_done4[NREQ-1:0]  = bus.done;
   end

   assign w_any_req = |bus.req;

   // Scan farthest-first so the nearest requester above r_rr overwrites the rest.
   always_comb begin : winner_scan
      logic [1:0] v_idx;
      v_idx = '0;
      w_win = r_rr;
      for (int i = NREQ; i >= 1; i--) begin
         v_idx = 2'((int'(r_rr) + i) % NREQ);
         if (w_req4[v_idx]) begin
            w_win = v_idx;
         end
      end
   end

   assign w_hold_nxt = (r_hold >= c_HOLD_MAX) ? r_hold : r_hold + 8'd1;
   assign w_own_exit = w_done4[r_owner] | ~w_req4[r_owner] | (w_hold_nxt >= c_HOLD_MAX);

   for (genvar g = 0; g < NREQ; g++) begin : g_gnt
      assign w_gnt[g] = (r_state == c_OWN) && (r_owner == 2'(g));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= c_IDLE;
         r_owner   <= '0;
         r_rr      <= '0;
         r_hold    <= '0;
         r_busy    <= 1'b0;
         r_br_n    <= 1'b1;
         r_bgack_n <= 1'b1;
      end else if (phi2) begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_br_n  <= 1'b0;
                  r_state <= c_WAIT_BG;
               end
            end
            c_WAIT_BG: begin
               if (!w_any_req) begin
                  r_br_n  <= 1'b1;
                  r_state <= c_IDLE;
               end else if (!bus.bg_n && bus.as_n) begin
                  // BGACK asserted and BR negated on the same strobe: no overlap.
                  r_bgack_n <= 1'b0;
                  r_br_n    <= 1'b1;
                  r_busy    <= 1'b1;
                  r_owner   <= w_win;
                  r_rr      <= w_win;
                  r_hold    <= '0;
                  r_state   <= c_OWN;
               end
            end
            c_OWN: begin
               r_hold <= w_hold_nxt;
               if (w_own_exit) begin
                  r_state <= c_DRAIN;
               end
            end
            c_DRAIN: begin
               if (bus.as_n) begin
                  if (w_any_req) begin
                     r_owner <= w_win;
                     r_rr    <= w_win;
                     r_hold  <= '0;
                     r_state <= c_OWN;
                  end else begin
                     r_bgack_n <= 1'b1;
                     r_busy    <= 1'b0;
                     r_state   <= c_REL;
                  end
               end
            end
            c_REL: begin
               r_state <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = w_gnt;
   assign bus.owner   = r_owner;
   assign bus.busy    = r_busy;
   assign bus.br_n    = r_br_n;
   assign bus.bgack_n = r_bgack_n;

endmodule

`default_nettype wire

// File: tb/tb_bus_master_arbiter.sv
// =============================================================================
// tb_bus_master_arbiter : directed stimulus with a grant scoreboard/monitor
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_bus_master_arbiter;

   localparam int NREQ = 3;
   localparam int HOLD = 8;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic phi2    = 1'b0;

   bus_master_arbiter_if #(.NREQ(NREQ)) bus ();

   bus_master_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .phi2    (phi2),
      .bus     (bus)
   );

   typedef struct {
      int owner;
      int gap;   // gnt=0 strobes before this grant, -1 = don't care
      int len;   // strobes with gnt high, -1 = don't care
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(negedge clk) phi2 = ~phi2;

   function automatic void chk(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic strobe(int n);
      repeat (n) begin
         do @(posedge clk); while (!phi2);
         #1;
      end
   endtask

   task automatic own_done(int o, logic [NREQ-1:0] req_after);
      strobe(1);
      bus.done = 3'(1 << o);
      bus.req  = req_after;
      strobe(1);
      bus.done = '0;
   endtask

   // Monitor: pops an expectation at every new grant and checks invariants per strobe
   logic [NREQ-1:0] m_prev    = '0;
   int              m_zero    = 0;
   int              m_len     = 0;
   int              m_exp_len = -1;

   initial begin
      exp_t e;
      forever begin
         do @(posedge clk); while (!phi2);
         #1;
         chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
         chk("br_and_bgack_both_low", int'(!bus.br_n && !bus.bgack_n), 0);
         chk("busy_vs_bgack", int'(bus.busy), int'(!bus.bgack_n));
         if (bus.gnt != '0 && bus.gnt != m_prev) begin
            chk("grant_switch_without_gap", int'(m_prev), 0);
            if (sb.size() == 0) begin
               chk("unexpected_grant", int'(bus.gnt), 0);
               m_exp_len = -1;
            end else begin
               e = sb.pop_front();
               chk("grant_owner", int'(bus.owner), e.owner);
               chk("grant_gnt", int'(bus.gnt), 1 << e.owner);
               if (e.gap >= 0) chk("grant_gap", m_zero, e.gap);
               m_exp_len = e.len;
            end
            m_len = 0;
         end
         if (bus.gnt != '0) begin
            m_len++;
         end else begin
            if (m_prev != '0) begin
               if (m_exp_len >= 0) chk("hold_len", m_len, m_exp_len);
               m_zero = 0;
            end
            m_zero++;
         end
         m_prev = bus.gnt;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got %0d vectors expected completion", n_vec);
      $fatal(1);
   end

   initial begin
      int owners [4] = '{1, 2, 0, 1};

      bus.req  = '0;
      bus.done = '0;
      bus.bg_n = 1'b1;
      bus.as_n = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_gnt",     int'(bus.gnt), 0);
      chk("rst_owner",   int'(bus.owner), 0);
      chk("rst_busy",    int'(bus.busy), 0);
      chk("rst_br_n",    int'(bus.br_n), 1);
      chk("rst_bgack_n", int'(bus.bgack_n), 1);
      @(negedge clk);
      reset_n = 1'b1;

      // T1 single requester
      sb.push_back('{0, -1, 3});
      bus.req = 3'b001;
      strobe(1);
      chk("t1_br_low",      int'(bus.br_n), 0);
      chk("t1_bgack_idle",  int'(bus.bgack_n), 1);
      strobe(1);
      chk("t1_br_still_low", int'(bus.br_n), 0);
      bus.bg_n = 1'b0;
      strobe(1);
      chk("t1_br_released", int'(bus.br_n), 1);
      chk("t1_bgack_low",   int'(bus.bgack_n), 0);
      chk("t1_gnt",         int'(bus.gnt), 1);
      strobe(2);
      chk("t1_gnt_held",    int'(bus.gnt), 1);
      bus.done = 3'b001;
      bus.req  = 3'b000;
      strobe(1);
      bus.done = '0;
      bus.bg_n = 1'b1;
      chk("t1_drain_gnt",   int'(bus.gnt), 0);
      chk("t1_drain_bgack", int'(bus.bgack_n), 0);
      strobe(1);
      chk("t1_rel_bgack",   int'(bus.bgack_n), 1);
      chk("t1_rel_busy",    int'(bus.busy), 0);
      chk("t1_rel_br",      int'(bus.br_n), 1);
      strobe(1);

      // T2 round robin 1,2,0,1 with one-strobe gaps
      sb.push_back('{1, -1, 2});
      sb.push_back('{2, 1, 2});
      sb.push_back('{0, 1, 2});
      sb.push_back('{1, 1, 2});
      bus.req  = 3'b111;
      bus.bg_n = 1'b0;
      strobe(2);
      bus.bg_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         own_done(owners[k], (k == 3) ? 3'b000 : 3'b111);
         chk("t2_gap_gnt",   int'(bus.gnt), 0);
         chk("t2_gap_bgack", int'(bus.bgack_n), 0);
         chk("t2_gap_br",    int'(bus.br_n), 1);
         strobe(1);
         if (k < 3) chk("t2_owner_direct", int'(bus.owner), owners[k+1]);
      end
      chk("t2_final_rel_bgack", int'(bus.bgack_n), 1);
      strobe(1);

      // T3 hold limit with non-owner done ignored
      sb.push_back('{1, -1, 8});
      sb.push_back('{2, 1, 2});
      bus.req  = 3'b010;
      bus.bg_n = 1'b0;
      strobe(2);
      bus.bg_n = 1'b1;
      bus.req  = 3'b110;
      strobe(2);
      bus.done = 3'b100;
      strobe(1);
      bus.done = '0;
      chk("t3_nonowner_done_ignored", int'(bus.gnt), 2);
      strobe(4);
      chk("t3_before_limit", int'(bus.gnt), 2);
      strobe(1);
      chk("t3_limit_drop", int'(bus.gnt), 0);
      strobe(1);
      chk("t3_next_gnt", int'(bus.gnt), 4);
      own_done(2, 3'b000);
      strobe(2);

      // T4 AS drain delays the next grant
      sb.push_back('{0, -1, 2});
      sb.push_back('{1, 6, 2});
      bus.req  = 3'b001;
      bus.bg_n = 1'b0;
      strobe(2);
      bus.bg_n = 1'b1;
      bus.req  = 3'b011;
      strobe(1);
      bus.done = 3'b001;
      bus.req  = 3'b010;
      bus.as_n = 1'b0;
      strobe(1);
      bus.done = '0;
      for (int k = 0; k < 5; k++) begin
         strobe(1);
         chk("t4_drain_hold", int'(bus.gnt), 0);
      end
      bus.as_n = 1'b1;
      strobe(1);
      chk("t4_gnt_after_as", int'(bus.gnt), 2);
      own_done(1, 3'b000);
      strobe(2);

      // T5 aborted request in WAIT_BG
      bus.req = 3'b100;
      strobe(1);
      chk("t5_br_low", int'(bus.br_n), 0);
      strobe(1);
      chk("t5_br_still_low", int'(bus.br_n), 0);
      bus.req = 3'b000;
      strobe(1);
      chk("t5_br_back", int'(bus.br_n), 1);
      chk("t5_bgack",   int'(bus.bgack_n), 1);
      strobe(2);
      chk("t5_bgack_later", int'(bus.bgack_n), 1);
      chk("t5_gnt",         int'(bus.gnt), 0);

      // T6 async reset mid-ownership
      sb.push_back('{2, -1, -1});
      sb.push_back('{1, -1, 2});
      bus.req  = 3'b100;
      bus.bg_n = 1'b0;
      strobe(2);
      bus.bg_n = 1'b1;
      strobe(1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_gnt",     int'(bus.gnt), 0);
      chk("t6_rst_bgack",   int'(bus.bgack_n), 1);
      chk("t6_rst_br",      int'(bus.br_n), 1);
      chk("t6_rst_busy",    int'(bus.busy), 0);
      chk("t6_rst_owner",   int'(bus.owner), 0);
      bus.req = 3'b110;
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      bus.bg_n = 1'b0;
      strobe(2);
      bus.bg_n = 1'b1;
      chk("t6_first_after_reset", int'(bus.owner), 1);
      own_done(1, 3'b000);
      strobe(3);

      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
